calc_cmd_sched: RTL and testbench

CALC_CMD_SCHED -- requirements
Module: calc_cmd_sched

---
 rtl/calc_cmd_sched.sv | 169 ++++++++++++++++
 tb/tb_calc_cmd_sched.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_cmd_sched.sv
// Keypad-to-calculator command scheduler: key FIFO, paced issue, ready wait,
// fault/user clear. Optional backspace merge enabled by CALC_SCHED_BKSP_MERGE_EN.
module calc_cmd_sched #(
  parameter int         DEPTH     = 4,
  parameter int         GAP       = 2,
  parameter int         TIMEOUT   = 64,
  parameter logic [3:0] IDLE_CODE = 4'hD
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   key_valid,
  input  logic [3:0]             key_code,
  output logic                   key_ready,
  input  logic                   clr_req,
  input  logic [1:0]             calc_status,
  output logic [3:0]             calc_cmd,
  output logic                   calc_clr,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             fault_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = $clog2(GAP + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, HOLD, WAIT_READY, CLEAR} state_t;

  state_t        state_q;
  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q;
  logic [AW-1:0] rdPtr_q;
  logic [LW-1:0] count_q;
  logic [LW-1:0] count_d;
  logic [GW-1:0] gapCnt_q;
  logic [TW-1:0] timer_q;
  logic          clrCnt_q;
  logic [3:0]    calcCmd_q;
  logic          calcClr_q;
  logic [7:0]    faultCnt_q;

  logic statusErr;
  logic statusRdy;
  logic fifoEmpty;
  logic fifoFull;
  logic faultClear;
  logic goClear;
  logic doPop;
  logic offered;
  logic doMerge;
  logic doStore;

  assign statusErr = (calc_status == 2'b00);
  assign statusRdy = (calc_status == 2'b10);
  assign fifoEmpty = (count_q == '0);
  assign fifoFull  = (count_q == LW'(DEPTH));

  // A fault sends us to CLEAR; the timeout fires on the last allowed WAIT_READY cycle.
  always_comb begin
    faultClear = 1'b0;
    case (state_q)
      IDLE:       faultClear = statusErr;
      HOLD:       faultClear = statusErr;
      WAIT_READY: faultClear = statusErr || (!statusRdy && (timer_q == TW'(TIMEOUT - 1)));
      default:    faultClear = 1'b0;
    endcase
  end

  assign goClear = clr_req || faultClear;
  assign doPop   = (state_q == IDLE) && !fifoEmpty && statusRdy && !goClear;
  assign offered = key_valid && !fifoFull && !goClear;

`ifdef CALC_SCHED_BKSP_MERGE_EN
  logic [AW-1:0] tailPtr;
  logic          tailIsDigit;
  assign tailPtr     = wrPtr_q - AW'(1);
  assign tailIsDigit = !fifoEmpty && (mem_q[tailPtr] <= 4'd9);
  // The lone entry leaving this cycle cannot be cancelled, so F is kept instead.
  assign doMerge = offered && (key_code == 4'hF) && tailIsDigit &&
                   !(doPop && (count_q == LW'(1)));
`else
  assign doMerge = 1'b0;
`endif

  assign doStore = offered && !doMerge;
  assign count_d = count_q + LW'(doStore) - LW'(doPop) - LW'(doMerge);

  always_ff @(posedge clock) begin
    if (doStore) mem_q[wrPtr_q] <= key_code;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else if (goClear) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doStore)      wrPtr_q <= wrPtr_q + AW'(1);
      else if (doMerge) wrPtr_q <= wrPtr_q - AW'(1);
      if (doPop)        rdPtr_q <= rdPtr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Head is captured on the IDLE->ISSUE edge so calc_cmd shows it only during ISSUE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      gapCnt_q   <= '0;
      timer_q    <= '0;
      clrCnt_q   <= 1'b0;
      calcCmd_q  <= IDLE_CODE;
      calcClr_q  <= 1'b0;
      faultCnt_q <= '0;
    end else begin
      calcCmd_q <= doPop ? mem_q[rdPtr_q] : IDLE_CODE;
      if (goClear) begin
        state_q   <= CLEAR;
        clrCnt_q  <= 1'b0;
        calcClr_q <= 1'b1;
        if (!clr_req && (faultCnt_q != 8'hFF)) faultCnt_q <= faultCnt_q + 8'd1;
      end else begin
        case (state_q)
          IDLE: begin
            if (doPop) state_q <= ISSUE;
          end
          ISSUE: begin
            state_q  <= HOLD;
            gapCnt_q <= '0;
          end
          HOLD: begin
            if (gapCnt_q == GW'(GAP - 1)) begin
              state_q <= WAIT_READY;
              timer_q <= '0;
            end else begin
              gapCnt_q <= gapCnt_q + GW'(1);
            end
          end
          WAIT_READY: begin
            if (statusRdy) state_q <= IDLE;
            else           timer_q <= timer_q + TW'(1);
          end
          CLEAR: begin
            if (clrCnt_q) begin
              state_q   <= IDLE;
              calcClr_q <= 1'b0;
            end else begin
              clrCnt_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign key_ready = !fifoFull;
  assign calc_cmd  = calcCmd_q;
  assign calc_clr  = calcClr_q;
  assign busy      = (state_q != IDLE);
  assign level     = count_q;
  assign fault_cnt = faultCnt_q;

endmodule

// File: tb/tb_calc_cmd_sched.sv
// Self-checking bench for calc_cmd_sched: a directed vector table, hand-written
// multi-cycle corner sequences, and random traffic against a queue-based model.
module tb_calc_cmd_sched;

  localparam int         DEPTH     = 4;
  localparam int         GAP       = 2;
  localparam int         TIMEOUT   = 64;
  localparam logic [3:0] IDLE_CODE = 4'hD;
`ifdef CALC_SCHED_BKSP_MERGE_EN
  localparam bit MERGE_ON = 1'b1;
`else
  localparam bit MERGE_ON = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic       clr_req;
  logic [1:0] calc_status;
  logic [3:0] calc_cmd;
  logic       calc_clr;
  logic       busy;
  logic [2:0] level;
  logic [7:0] fault_cnt;

  int errors = 0;
  int checks = 0;

  calc_cmd_sched #(
    .DEPTH(DEPTH), .GAP(GAP), .TIMEOUT(TIMEOUT), .IDLE_CODE(IDLE_CODE)
  ) dut (
    .clock(clock), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .clr_req(clr_req), .calc_status(calc_status),
    .calc_cmd(calc_cmd), .calc_clr(calc_clr), .busy(busy), .level(level),
    .fault_cnt(fault_cnt)
  );

  always #5 clock = ~clock;

  // Reference model: a queue of pending keys plus countdowns for each phase.
  typedef enum {P_IDLE, P_ISSUE, P_HOLD, P_WAIT, P_CLEAR} phase_t;
  int         q[$];
  phase_t     phase;
  int         holdLeft;
  int         waitLeft;
  int         clrLeft;
  int         faults;
  logic [3:0] expCmd;

  function automatic void modelReset();
    q.delete();
    phase    = P_IDLE;
    holdLeft = 0;
    waitLeft = 0;
    clrLeft  = 0;
    faults   = 0;
    expCmd   = IDLE_CODE;
  endfunction

  function automatic void modelStep(bit kv, logic [3:0] kc, bit clr, logic [1:0] st);
    bit err, rdy, fault, takeHead, takeKey;
    err   = (st == 2'b00);
    rdy   = (st == 2'b10);
    fault = ((phase == P_IDLE || phase == P_HOLD) && err) ||
            (phase == P_WAIT && (err || (!rdy && waitLeft == 1)));
    expCmd = IDLE_CODE;
    if (clr || fault) begin
      q.delete();
      if (!clr && faults < 255) faults++;
      phase   = P_CLEAR;
      clrLeft = 2;
      return;
    end
    takeHead = (phase == P_IDLE) && (q.size() > 0) && rdy;
    takeKey  = kv && (q.size() < DEPTH);
    if (takeKey && MERGE_ON && kc == 4'hF && q.size() > 0 && q[q.size()-1] <= 9 &&
        !(takeHead && q.size() == 1)) begin
      void'(q.pop_back());
      takeKey = 1'b0;
    end
    if (takeHead) expCmd = 4'(q.pop_front());
    if (takeKey) q.push_back(int'(kc));
    case (phase)
      P_IDLE:  if (takeHead) phase = P_ISSUE;
      P_ISSUE: begin phase = P_HOLD; holdLeft = GAP; end
      P_HOLD:  begin
        holdLeft--;
        if (holdLeft == 0) begin phase = P_WAIT; waitLeft = TIMEOUT; end
      end
      P_WAIT:  if (rdy) phase = P_IDLE; else waitLeft--;
      P_CLEAR: begin clrLeft--; if (clrLeft == 0) phase = P_IDLE; end
      default: ;
    endcase
  endfunction

  // Drive one cycle of inputs, advance the model, and land #1 after the edge.
  task automatic applyStimulus(input bit kv, input logic [3:0] kc, input bit clr,
                               input logic [1:0] st);
    key_valid   = kv;
    key_code    = kc;
    clr_req     = clr;
    calc_status = st;
    modelStep(kv, kc, clr, st);
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eCmd, input bit eClr,
                             input bit eBusy, input int eLevel, input bit eRdy,
                             input int eFault);
    checks++;
    if (calc_cmd !== eCmd || calc_clr !== eClr || busy !== eBusy ||
        level !== 3'(eLevel) || key_ready !== eRdy || fault_cnt !== 8'(eFault)) begin
      errors++;
      $display("[TB] FAIL %s: got cmd=%h clr=%b busy=%b level=%0d ready=%b faults=%0d, expected cmd=%h clr=%b busy=%b level=%0d ready=%b faults=%0d",
               name, calc_cmd, calc_clr, busy, level, key_ready, fault_cnt,
               eCmd, eClr, eBusy, eLevel, eRdy, eFault);
    end
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, expCmd, phase == P_CLEAR, phase != P_IDLE, q.size(),
                q.size() < DEPTH, faults);
  endtask

  task automatic checkValue(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic stepChecked(input string name, input bit kv, input logic [3:0] kc,
                             input bit clr, input logic [1:0] st);
    applyStimulus(kv, kc, clr, st);
    checkModel(name);
  endtask

  typedef struct {
    bit         kv;
    logic [3:0] kc;
    bit         clr;
    logic [1:0] st;
    logic [3:0] eCmd;
    bit         eClr;
    bit         eBusy;
    int         eLevel;
    bit         eRdy;
    int         eFault;
  } vec_t;
  vec_t vecs[$];

  task automatic addVec(input bit kv, input logic [3:0] kc, input bit clr, input logic [1:0] st,
                        input logic [3:0] eCmd, input bit eClr, input bit eBusy,
                        input int eLevel, input bit eRdy, input int eFault);
    vec_t v;
    v.kv = kv; v.kc = kc; v.clr = clr; v.st = st;
    v.eCmd = eCmd; v.eClr = eClr; v.eBusy = eBusy;
    v.eLevel = eLevel; v.eRdy = eRdy; v.eFault = eFault;
    vecs.push_back(v);
  endtask

  logic [3:0] seq039 [4] = '{4'h3, 4'hA, 4'h4, 4'hE};
  int         cmdVals[$];
  int         cmdTimes[$];
  int         n;
  int         f0;
  int         r;
  logic [1:0] rst;

  initial begin
    // Status 11 while filling, overflow drop, one paced issue, clr with key, fault in IDLE.
    addVec(1, 4'h1, 0, 2'b11, 4'hD, 0, 0, 1, 1, 0);
    addVec(1, 4'h2, 0, 2'b11, 4'hD, 0, 0, 2, 1, 0);
    addVec(1, 4'h3, 0, 2'b11, 4'hD, 0, 0, 3, 1, 0);
    addVec(1, 4'h4, 0, 2'b11, 4'hD, 0, 0, 4, 0, 0);
    addVec(1, 4'h5, 0, 2'b11, 4'hD, 0, 0, 4, 0, 0);
    addVec(0, 4'h0, 0, 2'b11, 4'hD, 0, 0, 4, 0, 0);
    addVec(0, 4'h0, 0, 2'b10, 4'h1, 0, 1, 3, 1, 0);
    addVec(0, 4'h0, 0, 2'b10, 4'hD, 0, 1, 3, 1, 0);
    addVec(0, 4'h0, 0, 2'b01, 4'hD, 0, 1, 3, 1, 0);
    addVec(0, 4'h0, 0, 2'b01, 4'hD, 0, 1, 3, 1, 0);
    addVec(0, 4'h0, 0, 2'b10, 4'hD, 0, 0, 3, 1, 0);
    addVec(0, 4'h0, 0, 2'b10, 4'h2, 0, 1, 2, 1, 0);
    addVec(1, 4'h9, 1, 2'b10, 4'hD, 1, 1, 0, 1, 0);
    addVec(0, 4'h0, 0, 2'b10, 4'hD, 1, 1, 0, 1, 0);
    addVec(0, 4'h0, 0, 2'b10, 4'hD, 0, 0, 0, 1, 0);
    addVec(0, 4'h0, 0, 2'b00, 4'hD, 1, 1, 0, 1, 1);
    addVec(0, 4'h0, 0, 2'b11, 4'hD, 1, 1, 0, 1, 1);
    addVec(0, 4'h0, 0, 2'b11, 4'hD, 0, 0, 0, 1, 1);

    reset       = 1'b1;
    key_valid   = 1'b0;
    key_code    = 4'h0;
    clr_req     = 1'b0;
    calc_status = 2'b11;
    modelReset();
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset", IDLE_CODE, 0, 0, 0, 1, 0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].kv, vecs[i].kc, vecs[i].clr, vecs[i].st);
      checkOutput($sformatf("vec%0d", i), vecs[i].eCmd, vecs[i].eClr, vecs[i].eBusy,
                  vecs[i].eLevel, vecs[i].eRdy, vecs[i].eFault);
    end

    // Keys 3,A,4,E back to back with the calculator ready.
    for (int t = 1; t <= 60; t++) begin
      stepChecked("seq039", t <= 4, seq039[(t - 1) & 3], 0, 2'b10);
      if (calc_cmd != IDLE_CODE) begin
        cmdVals.push_back(int'(calc_cmd));
        cmdTimes.push_back(t);
      end
    end
    checkValue("seq039 count", cmdVals.size(), 4);
    if (cmdVals.size() == 4) begin
      for (int i = 0; i < 4; i++) checkValue($sformatf("seq039 cmd%0d", i), cmdVals[i], int'(seq039[i]));
      checkValue("seq039 latency", cmdTimes[0], 2);
      for (int i = 1; i < 4; i++)
        checkValue($sformatf("seq039 spacing%0d ok", i), int'(cmdTimes[i] - cmdTimes[i-1] >= GAP + 2), 1);
    end
    checkValue("seq039 final level", int'(level), 0);

    // Error status after an issue: flush, two-cycle clear, one fault.
    stepChecked("seq041 fill", 1, 4'h6, 0, 2'b11);
    stepChecked("seq041 fill", 1, 4'h7, 0, 2'b11);
    stepChecked("seq041 fill", 1, 4'h8, 0, 2'b11);
    stepChecked("seq041 issue", 0, 4'h0, 0, 2'b10);
    f0 = faults;
    n = 0;
    while (!calc_clr && n < 10) begin
      stepChecked("seq041 err", 0, 4'h0, 0, 2'b00);
      n++;
    end
    checkValue("seq041 clear seen", int'(calc_clr), 1);
    checkValue("seq041 flushed", int'(level), 0);
    checkValue("seq041 faults", int'(fault_cnt), f0 + 1);
    n = 1;
    for (int i = 0; i < 10; i++) begin
      stepChecked("seq041 clr", 0, 4'h0, 0, 2'b11);
      if (calc_clr) n++;
      else break;
    end
    checkValue("seq041 clr cycles", n, 2);

    // Busy forever after an issue: timeout clear.
    stepChecked("seq042 push", 1, 4'h5, 0, 2'b10);
    stepChecked("seq042 issue", 0, 4'h0, 0, 2'b10);
    f0 = faults;
    n = 0;
    while (!calc_clr && n < 200) begin
      stepChecked("seq042 busy", 0, 4'h0, 0, 2'b01);
      n++;
    end
    checkValue("seq042 timeout cycles", n, GAP + TIMEOUT + 1);
    checkValue("seq042 faults", int'(fault_cnt), f0 + 1);
    stepChecked("seq042 out", 0, 4'h0, 0, 2'b11);
    stepChecked("seq042 out", 0, 4'h0, 0, 2'b11);

    // Digit followed by backspace while the calculator prints.
    stepChecked("seq043 7", 1, 4'h7, 0, 2'b11);
    stepChecked("seq043 F", 1, 4'hF, 0, 2'b11);
    checkValue("seq043 level", int'(level), MERGE_ON ? 0 : 2);
    stepChecked("seq043 clr", 0, 4'h0, 1, 2'b11);
    stepChecked("seq043 out", 0, 4'h0, 0, 2'b11);
    stepChecked("seq043 out", 0, 4'h0, 0, 2'b11);

    // User clear during HOLD does not count as a fault.
    stepChecked("seq044 push", 1, 4'h4, 0, 2'b10);
    stepChecked("seq044 issue", 0, 4'h0, 0, 2'b10);
    stepChecked("seq044 hold", 0, 4'h0, 0, 2'b01);
    f0 = faults;
    stepChecked("seq044 clr", 0, 4'h0, 1, 2'b01);
    checkValue("seq044 clr1", int'(calc_clr), 1);
    stepChecked("seq044 c2", 0, 4'h0, 0, 2'b11);
    checkValue("seq044 clr2", int'(calc_clr), 1);
    stepChecked("seq044 c3", 0, 4'h0, 0, 2'b11);
    checkValue("seq044 clr off", int'(calc_clr), 0);
    checkValue("seq044 faults", int'(fault_cnt), f0);

    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3)       rst = 2'b00;
      else if (r < 60) rst = 2'b10;
      else if (r < 80) rst = 2'b01;
      else             rst = 2'b11;
      stepChecked("random", $urandom_range(0, 2) != 0,
                  ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 15)),
                  $urandom_range(0, 49) == 0, rst);
    end

    for (int i = 0; i < 800; i++) stepChecked("saturate", 0, 4'h0, 0, 2'b00);
    checkValue("fault saturation", int'(fault_cnt), 255);
    for (int i = 0; i < 3; i++) stepChecked("saturate out", 0, 4'h0, 0, 2'b11);

    // Reset in the middle of CLEAR.
    stepChecked("rst clear", 0, 4'h0, 1, 2'b11);
    key_valid = 1'b0;
    clr_req   = 1'b0;
    reset     = 1'b1;
    #1;
    checkOutput("reset mid-clear", IDLE_CODE, 0, 0, 0, 1, 0);
    @(posedge clock);
    #1;
    checkOutput("reset mid-clear held", IDLE_CODE, 0, 0, 0, 1, 0);
    reset = 1'b0;
    modelReset();

    // Reset in the middle of an issue.
    stepChecked("rst issue push", 1, 4'h2, 0, 2'b10);
    stepChecked("rst issue", 0, 4'h0, 0, 2'b10);
    key_valid = 1'b0;
    reset     = 1'b1;
    #1;
    checkOutput("reset mid-issue", IDLE_CODE, 0, 0, 0, 1, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    modelReset();
    stepChecked("after reset", 0, 4'h0, 0, 2'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
